des_spi_cmd_ctrl: RTL and testbench

- Command/transaction controller between the 64-bit SPI slave and the DES core.
- Each completed 64-bit SPI frame (rx_word) is decoded as a command or as payload. The block holds the key, data and mode registers and drives the DES start/done handshake.
- It also selects the 64-bit reply word (tx_word) that the SPI slave preloads at the next chip-select assertion.
- The whole block runs in the sclk domain. State updates on the falling edge of sclk, so rx_word (updated by the SPI slave on the 64th rising edge) is already stable when sampled.

---
 rtl/des_spi_cmd_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_des_spi_cmd_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/des_spi_cmd_ctrl.sv
// Command/transaction controller between a 64-bit SPI slave and a DES core (sclk domain, falling edge).
// Build macro DES_CMD_CHECK_EN: command frames must carry ~opcode in [55:48] and zeros in [47:0].
module des_spi_cmd_ctrl #(
    parameter logic [7:0]  STATUS_TAG = 8'h5A,
    parameter int unsigned TIMEOUT    = 128
) (
    input  logic        rst,
    input  logic        sclk,
    input  logic        i_cs_n,
    input  logic [63:0] i_rx_word,
    output logic [63:0] o_tx_word,
    output logic [63:0] o_des_key,
    output logic [63:0] o_des_din,
    output logic        o_des_decrypt,
    output logic        o_des_start,
    input  logic [63:0] i_des_dout,
    input  logic        i_des_done,
    output logic        o_err
);
    localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [7:0] OP_NOP         = 8'h00;
    localparam logic [7:0] OP_LOAD_KEY    = 8'h01;
    localparam logic [7:0] OP_ENCRYPT     = 8'h02;
    localparam logic [7:0] OP_DECRYPT     = 8'h03;
    localparam logic [7:0] OP_READ_RESULT = 8'h04;
    localparam logic [7:0] OP_STATUS      = 8'h05;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_DATA = 2'd2,
        ST_BUSY = 2'd3
    } state_t;

    state_t          r_state;
    logic [5:0]      r_bit_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [63:0]     r_result;
    logic            r_result_valid;
    logic [63:0]     r_tx_word;
    logic [63:0]     r_des_key;
    logic [63:0]     r_des_din;
    logic            r_des_decrypt;
    logic            r_des_start;
    logic            r_err;

    logic            w_frame;
    logic [7:0]      w_op;
    logic            w_cmd_ok;
    logic            w_busy_done;
    logic            w_timeout;
    logic            w_cmd_illegal;
    logic            w_err_set;
    logic            w_err_clr;
    logic            w_busy_nx;
    logic            w_rv_nx;
    logic [63:0]     w_status;

    function automatic logic [63:0] status_word(input logic err, input logic busy, input logic rv);
        return {STATUS_TAG, 53'd0, err, busy, rv};
    endfunction

    assign w_frame     = ~i_cs_n & (r_bit_cnt == 6'd63);
    assign w_op        = i_rx_word[63:56];
    assign w_busy_done = (r_state == ST_BUSY) & i_des_done;

`ifdef DES_CMD_CHECK_EN
    assign w_cmd_ok = (i_rx_word[55:48] == ~i_rx_word[63:56]) & (i_rx_word[47:0] == 48'd0);
`else
    assign w_cmd_ok = 1'b1;
`endif

    // A zero TIMEOUT removes the BUSY watchdog entirely.
    generate
        if (TIMEOUT != 0) begin : g_timeout
            assign w_timeout = (r_state == ST_BUSY) & ~i_des_done &
                               (r_to_cnt == TO_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Frame decode: error set/clear and the post-edge flags shown in the status reply.
    always_comb begin
        w_cmd_illegal = 1'b0;
        w_err_clr     = 1'b0;
        w_busy_nx     = (r_state == ST_BUSY) & ~w_busy_done & ~w_timeout;
        w_rv_nx       = r_result_valid | w_busy_done;
        if (w_frame) begin
            case (r_state)
                ST_IDLE, ST_BUSY: begin
                    if (!w_cmd_ok) begin
                        w_cmd_illegal = 1'b1;
                    end else begin
                        case (w_op)
                            OP_NOP, OP_READ_RESULT:              w_cmd_illegal = 1'b0;
                            OP_STATUS:                           w_err_clr     = 1'b1;
                            OP_LOAD_KEY, OP_ENCRYPT, OP_DECRYPT: w_cmd_illegal = (r_state == ST_BUSY);
                            default:                             w_cmd_illegal = 1'b1;
                        endcase
                    end
                end
                ST_DATA: begin
                    w_busy_nx = 1'b1;
                    w_rv_nx   = 1'b0;
                end
                default: w_cmd_illegal = 1'b0;
            endcase
        end else begin
            w_cmd_illegal = 1'b0;
        end
        w_err_set = w_timeout | w_cmd_illegal;
        // A STATUS reply still reports the error it is about to clear.
        w_status  = status_word(r_err | w_err_set, w_busy_nx, w_rv_nx);
    end

    // Bit counter within a frame; chip-select high discards a partial frame at once.
    always_ff @(negedge sclk or negedge rst or posedge i_cs_n) begin
        if (!rst) begin
            r_bit_cnt <= 6'd0;
        end else if (i_cs_n) begin
            r_bit_cnt <= 6'd0;
        end else begin
            r_bit_cnt <= r_bit_cnt + 6'd1;
        end
    end

    // Command FSM, DES handshake, result capture and reply selection.
    always_ff @(negedge sclk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_to_cnt       <= '0;
            r_result       <= 64'd0;
            r_result_valid <= 1'b0;
            r_tx_word      <= status_word(1'b0, 1'b0, 1'b0);
            r_des_key      <= 64'd0;
            r_des_din      <= 64'd0;
            r_des_decrypt  <= 1'b0;
            r_des_start    <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_des_start <= 1'b0;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_err_clr) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end

            if (w_busy_done) begin
                r_result       <= i_des_dout;
                r_result_valid <= 1'b1;
                r_state        <= ST_IDLE;
            end else if (w_timeout) begin
                r_state <= ST_IDLE;
            end else if (r_state == ST_BUSY) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= r_to_cnt;
            end

            if (w_frame) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cmd_illegal) begin
                            r_tx_word <= w_status;
                        end else begin
                            case (w_op)
                                OP_LOAD_KEY: begin
                                    r_state   <= ST_KEY;
                                    r_tx_word <= w_status;
                                end
                                OP_ENCRYPT: begin
                                    r_des_decrypt <= 1'b0;
                                    r_state       <= ST_DATA;
                                    r_tx_word     <= w_status;
                                end
                                OP_DECRYPT: begin
                                    r_des_decrypt <= 1'b1;
                                    r_state       <= ST_DATA;
                                    r_tx_word     <= w_status;
                                end
                                OP_READ_RESULT: begin
                                    r_tx_word <= r_result_valid ? r_result : w_status;
                                end
                                default: r_tx_word <= w_status;
                            endcase
                        end
                    end
                    ST_KEY: begin
                        r_des_key <= i_rx_word;
                        r_state   <= ST_IDLE;
                        r_tx_word <= w_status;
                    end
                    ST_DATA: begin
                        r_des_din      <= i_rx_word;
                        r_des_start    <= 1'b1;
                        r_result_valid <= 1'b0;
                        r_to_cnt       <= '0;
                        r_state        <= ST_BUSY;
                        r_tx_word      <= w_status;
                    end
                    ST_BUSY: r_tx_word <= w_status;
                    default: begin
                        r_state   <= ST_IDLE;
                        r_tx_word <= w_status;
                    end
                endcase
            end else begin
                r_tx_word <= r_tx_word;
            end
        end
    end

    assign o_tx_word     = r_tx_word;
    assign o_des_key     = r_des_key;
    assign o_des_din     = r_des_din;
    assign o_des_decrypt = r_des_decrypt;
    assign o_des_start   = r_des_start;
    assign o_err         = r_err;

endmodule

// File: tb/tb_des_spi_cmd_ctrl.sv
// Self-checking bench for des_spi_cmd_ctrl: directed steps, then random frames against a
// transaction-level reference model; an emulated DES core answers start pulses.
module tb_des_spi_cmd_ctrl;
    localparam int TMO = 128;

    logic        rst;
    logic        sclk;
    logic        i_cs_n;
    logic [63:0] i_rx_word;
    logic [63:0] o_tx_word;
    logic [63:0] o_des_key;
    logic [63:0] o_des_din;
    logic        o_des_decrypt;
    logic        o_des_start;
    logic [63:0] i_des_dout;
    logic        i_des_done;
    logic        o_err;

    des_spi_cmd_ctrl dut (
        .rst(rst), .sclk(sclk), .i_cs_n(i_cs_n), .i_rx_word(i_rx_word),
        .o_tx_word(o_tx_word), .o_des_key(o_des_key), .o_des_din(o_des_din),
        .o_des_decrypt(o_des_decrypt), .o_des_start(o_des_start),
        .i_des_dout(i_des_dout), .i_des_done(i_des_done), .o_err(o_err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: transaction-level view of the controller
    logic [63:0] m_key, m_din, m_result, m_tx;
    bit          m_dec, m_start, m_err, m_rv, m_busy;
    int          m_pend;   // 0 none, 1 key payload expected, 2 data payload expected
    int          m_age;    // falling edges spent waiting for the core

    // emulated DES core
    int          core_cnt = 0;
    logic [63:0] core_out = 64'd0;
    int          next_lat = 20;
    logic [63:0] next_out = 64'd0;
    bit          rand_done_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit frame, input logic [63:0] w, input bit done,
                              input logic [63:0] dout);
        bit eset, eclr, busy_a, rv_a, st_reply;
        logic [7:0] op;
        eset = 1'b0; eclr = 1'b0; m_start = 1'b0;
        busy_a = m_busy; rv_a = m_rv;
        if (m_busy) begin
            if (done) begin
                m_result = dout; rv_a = 1'b1; busy_a = 1'b0;
            end else begin
                m_age++;
                if (m_age >= TMO) begin eset = 1'b1; busy_a = 1'b0; end
            end
        end
        if (frame) begin
            op = w[63:56];
            st_reply = 1'b1;
            if (m_pend == 1) begin
                m_key = w; m_pend = 0;
            end else if (m_pend == 2) begin
                m_din = w; m_start = 1'b1; rv_a = 1'b0; busy_a = 1'b1; m_age = 0; m_pend = 0;
            end else begin
                case (op)
                    8'd0: ;
                    8'd4: if (!m_busy && m_rv) begin st_reply = 1'b0; m_tx = m_result; end
                    8'd5: eclr = 1'b1;
                    8'd1: if (m_busy) eset = 1'b1; else m_pend = 1;
                    8'd2, 8'd3: if (m_busy) eset = 1'b1; else begin m_dec = (op == 8'd3); m_pend = 2; end
                    default: eset = 1'b1;
                endcase
            end
            if (st_reply) m_tx = {8'h5A, 53'd0, m_err | eset, busy_a, rv_a};
        end
        m_err  = eset ? 1'b1 : (eclr ? 1'b0 : m_err);
        m_busy = busy_a;
        m_rv   = rv_a;
    endtask

    // one falling edge: drive inputs, advance the model, compare every output
    task automatic tick(input bit frame, input logic [63:0] w);
        bit dn;
        dn = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) dn = 1'b1;
        end
        if (rand_done_en && $urandom_range(0, 63) == 0) dn = 1'b1;
        i_des_done = dn;
        i_des_dout = core_out;
        i_rx_word  = frame ? w : {$urandom, $urandom};
        model_edge(frame && !i_cs_n, w, dn, core_out);
        @(negedge sclk);
        #1;
        chk("tx_word", o_tx_word, m_tx);
        chk("des_key", o_des_key, m_key);
        chk("des_din", o_des_din, m_din);
        chk("des_decrypt", {63'd0, o_des_decrypt}, {63'd0, m_dec});
        chk("des_start", {63'd0, o_des_start}, {63'd0, m_start});
        chk("err", {63'd0, o_err}, {63'd0, m_err});
        i_des_done = 1'b0;
        if (m_start && next_lat > 0) begin
            core_cnt = next_lat;
            core_out = next_out;
        end
    endtask

    task automatic send_frame(input logic [63:0] w);
        i_cs_n = 1'b0;
        for (int i = 0; i < 63; i++) tick(1'b0, 64'd0);
        tick(1'b1, w);
    endtask

    task automatic gap();
        i_cs_n = 1'b1;
        tick(1'b0, 64'd0);
    endtask

    task automatic abort_frame(input int nbits);
        i_cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) tick(1'b0, 64'd0);
        gap();
    endtask

    function automatic logic [63:0] cmd(input logic [7:0] op);
        return {op, 56'd0};
    endfunction

    initial begin
        rst = 1'b1; i_cs_n = 1'b1; i_rx_word = 64'd0; i_des_dout = 64'd0; i_des_done = 1'b0;
        #2 rst = 1'b0;
        @(negedge sclk); @(negedge sclk); #1;
        chk("reset_tx", o_tx_word, 64'h5A00_0000_0000_0000);
        chk("reset_key", o_des_key, 64'd0);
        chk("reset_din", o_des_din, 64'd0);
        chk("reset_ctl", {61'd0, o_des_decrypt, o_des_start, o_err}, 64'd0);
        rst = 1'b1;
        m_key = 64'd0; m_din = 64'd0; m_result = 64'd0; m_tx = 64'h5A00_0000_0000_0000;
        m_dec = 1'b0; m_start = 1'b0; m_err = 1'b0; m_rv = 1'b0; m_busy = 1'b0;
        m_pend = 0; m_age = 0;

        send_frame(cmd(8'h05));
        chk("status_after_reset", o_tx_word, 64'h5A00_0000_0000_0000);

        // encrypt the classic DES example
        next_lat = 20; next_out = 64'h85E813540F0AB405;
        send_frame(cmd(8'h01)); send_frame(64'h133457799BBCDFF1);
        send_frame(cmd(8'h02)); send_frame(64'h0123456789ABCDEF);
        chk("enc_start", {62'd0, o_des_start, o_des_decrypt}, 64'd2);
        send_frame(cmd(8'h00));
        send_frame(cmd(8'h04));
        chk("enc_result", o_tx_word, 64'h85E813540F0AB405);

        // decrypt it back
        next_out = 64'h0123456789ABCDEF;
        send_frame(cmd(8'h03)); send_frame(64'h85E813540F0AB405);
        chk("dec_mode", {63'd0, o_des_decrypt}, 64'd1);
        send_frame(cmd(8'h00));
        send_frame(cmd(8'h05));
        chk("dec_status", o_tx_word, 64'h5A00_0000_0000_0001);

        // partial key frame discarded, then a full one
        send_frame(cmd(8'h01));
        abort_frame(30);
        send_frame(64'hFFFF_FFFF_FFFF_FFFF);
        chk("abort_key", o_des_key, 64'hFFFF_FFFF_FFFF_FFFF);
        send_frame(cmd(8'h05));
        chk("abort_idle", o_tx_word, 64'h5A00_0000_0000_0001);

        // illegal opcode, sticky error cleared by STATUS
        send_frame(cmd(8'h77));
        chk("illegal_err", {63'd0, o_err}, 64'd1);
        send_frame(cmd(8'h05));
        chk("illegal_status1", o_tx_word, 64'h5A00_0000_0000_0005);
        send_frame(cmd(8'h05));
        chk("illegal_status2", o_tx_word, 64'h5A00_0000_0000_0001);

        // core never answers: watchdog
        next_lat = 0;
        send_frame(cmd(8'h02)); send_frame(64'h1111_2222_3333_4444);
        gap(); send_frame(cmd(8'h00)); send_frame(cmd(8'h00));
        chk("timeout_err", {63'd0, o_err}, 64'd1);
        send_frame(cmd(8'h04));
        chk("timeout_read", o_tx_word, 64'h5A00_0000_0000_0004);
        send_frame(cmd(8'h05));
        chk("timeout_status1", o_tx_word, 64'h5A00_0000_0000_0004);
        send_frame(cmd(8'h05));
        chk("timeout_status2", o_tx_word, 64'h5A00_0000_0000_0000);

        // command while busy, then done coincident with STATUS completion
        next_lat = 100; next_out = 64'hA5A5_0F0F_1234_5678;
        send_frame(cmd(8'h02)); send_frame(64'h5555_6666_7777_8888);
        send_frame(cmd(8'h01));
        chk("busy_cmd_err", {63'd0, o_err}, 64'd1);
        chk("busy_key_kept", o_des_key, 64'hFFFF_FFFF_FFFF_FFFF);
        send_frame(cmd(8'h05));
        chk("busy_status", o_tx_word, 64'h5A00_0000_0000_0005);
        next_lat = 64; next_out = 64'h0BAD_CAFE_DEAD_BEEF;
        send_frame(cmd(8'h03)); send_frame(64'h9999_AAAA_BBBB_CCCC);
        send_frame(cmd(8'h05));
        chk("simul_status", o_tx_word, 64'h5A00_0000_0000_0001);
        send_frame(cmd(8'h04));
        chk("simul_result", o_tx_word, 64'h0BAD_CAFE_DEAD_BEEF);

        // random frames, gaps, aborts and stray done pulses
        rand_done_en = 1'b1;
        for (int f = 0; f < 160; f++) begin
            int k;
            logic [7:0] op;
            k = int'($urandom_range(0, 9));
            if (k <= 5) op = 8'(k);
            else if (k == 6) op = 8'(6 + $urandom_range(0, 249));
            else op = 8'($urandom);
            next_lat = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 160));
            next_out = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) abort_frame(int'($urandom_range(1, 62)));
            if ($urandom_range(0, 2) == 0) gap();
            send_frame({op, 24'($urandom), 32'($urandom)});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
